// File: rtl/ami_rsplit.sv
// Splits one read descriptor into 4 KB-safe INCR bursts of at most MAX_BL beats and forwards R data.
// AR issue starts the cycle after accept; R path is zero-latency; AR stalls at AMI_OD outstanding bursts.
module ami_rsplit #(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int MAX_BL = 16,
  parameter int AMI_OD = 4,
  parameter int CLW    = 24
) (
  input  logic              usr_clk,
  input  logic              usr_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AXI_AW-1:0] cmd_addr,
  input  logic [CLW-1:0]    cmd_beats,
  input  logic [AXI_IW-1:0] cmd_id,
  output logic [AXI_IW-1:0] usr_arid,
  output logic [AXI_AW-1:0] usr_araddr,
  output logic [AXI_LW-1:0] usr_arlen,
  output logic [AXI_SW-1:0] usr_arsize,
  output logic [1:0]        usr_arburst,
  output logic              usr_arvalid,
  input  logic              usr_arready,
  input  logic [AXI_IW-1:0] usr_rid,
  input  logic [AXI_DW-1:0] usr_rdata,
  input  logic [1:0]        usr_rresp,
  input  logic              usr_rlast,
  input  logic              usr_rvalid,
  output logic              usr_rready,
  output logic [AXI_DW-1:0] dat_data,
  output logic              dat_last,
  output logic              dat_valid,
  input  logic              dat_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BYTES = AXI_DW / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int OW    = $clog2(AMI_OD + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [AXI_AW-1:0] addr_q;
  logic [CLW-1:0]    rem_q;
  logic [CLW-1:0]    left_q;
  logic [AXI_IW-1:0] id_q;
  logic [OW-1:0]     out_q, out_n;
  logic              arvalid_q, arvalid_d;
  logic [AXI_LW-1:0] arlen_q;
  logic [AXI_SW-1:0] arsize_q;
  logic [1:0]        arburst_q;
  logic              err_q;

  logic              accept, ar_hs, r_hs, r_end;
  logic [AXI_AW-1:0] cmd_addr_al, addr_n;
  logic [CLW-1:0]    rem_n;
  logic [AXI_LW:0]   cur_beats, first_beats, next_beats;
  logic              unused_rid;

  // Beats allowed from this address: limited by remaining, MAX_BL and the room left in the 4 KB page.
  function automatic logic [AXI_LW:0] burst_beats(input logic [11:0] lo, input logic [CLW-1:0] rem);
    logic [31:0] room;
    logic [31:0] n;
    room = (32'd4096 - {20'd0, lo}) >> BSH;
    n = 32'(rem);
    if (n > 32'(MAX_BL)) n = 32'(MAX_BL);
    if (n > room) n = room;
    return n[AXI_LW:0];
  endfunction

  function automatic logic [AXI_LW-1:0] len_of(input logic [AXI_LW:0] b);
    logic [AXI_LW:0] l;
    l = (b == '0) ? '0 : b - (AXI_LW+1)'(1);
    return l[AXI_LW-1:0];
  endfunction

  assign unused_rid  = ^usr_rid;

  assign cmd_ready   = usr_reset_n & (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;

  assign usr_rready  = dat_ready & busy;
  assign dat_valid   = usr_rvalid & busy;
  assign dat_data    = usr_rdata;
  assign dat_last    = (left_q == CLW'(1));

  assign usr_arvalid = arvalid_q;
  assign usr_araddr  = addr_q;
  assign usr_arlen   = arlen_q;
  assign usr_arsize  = arsize_q;
  assign usr_arburst = arburst_q;
  assign usr_arid    = id_q;

  assign accept      = cmd_valid & cmd_ready;
  assign ar_hs       = arvalid_q & usr_arready;
  assign r_hs        = usr_rvalid & usr_rready;
  assign r_end       = r_hs & usr_rlast;

  assign cmd_addr_al = cmd_addr & ~AXI_AW'(BYTES - 1);
  assign first_beats = burst_beats(cmd_addr_al[11:0], cmd_beats);
  assign cur_beats   = {1'b0, arlen_q} + (AXI_LW+1)'(1);
  assign addr_n      = addr_q + (AXI_AW'(cur_beats) << BSH);
  assign rem_n       = rem_q - CLW'(cur_beats);
  assign next_beats  = burst_beats(addr_n[11:0], rem_n);

  always_comb begin
    out_n = out_q;
    if (ar_hs && !r_end)      out_n = out_q + OW'(1);
    else if (!ar_hs && r_end) out_n = out_q - OW'(1);
  end

  always_comb begin
    state_d   = state_q;
    arvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = (cmd_beats == '0) ? S_DONE : S_ISSUE;
          arvalid_d = (cmd_beats != '0);
        end
      end
      S_ISSUE: begin
        // A presented AR is held until taken; a new one is raised only with room in the outstanding window.
        arvalid_d = arvalid_q;
        if (ar_hs) begin
          arvalid_d = (rem_n != '0) && (out_n < OW'(AMI_OD));
          if (rem_n == '0) state_d = S_WAIT;
        end else if (!arvalid_q) begin
          arvalid_d = (out_n < OW'(AMI_OD));
        end
      end
      S_WAIT: begin
        if (r_hs && (left_q == CLW'(1))) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      left_q    <= '0;
      id_q      <= '0;
      out_q     <= '0;
      arvalid_q <= 1'b0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      out_q     <= out_n;
      if (accept) begin
        addr_q    <= cmd_addr_al;
        rem_q     <= cmd_beats;
        left_q    <= cmd_beats;
        id_q      <= cmd_id;
        arlen_q   <= len_of(first_beats);
        arsize_q  <= AXI_SW'(BSH);
        arburst_q <= 2'b01;
        err_q     <= 1'b0;
      end else begin
        if (ar_hs) begin
          addr_q  <= addr_n;
          rem_q   <= rem_n;
          arlen_q <= len_of(next_beats);
        end
        if (r_hs) begin
          left_q <= left_q - CLW'(1);
          if (usr_rresp != 2'b00) err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ami_rsplit.sv
// Randomized bench for ami_rsplit: a random AXI slave and sink driven against a burst-list reference model.
module tb_ami_rsplit;
  localparam int DW = 128, AW = 32, IW = 8, LW = 8, SW = 3, MBL = 16, OD = 4, CLW = 24;

  logic          clk = 1'b0;
  logic          usr_reset_n;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [CLW-1:0] cmd_beats;
  logic [IW-1:0] cmd_id;
  logic [IW-1:0] usr_arid;
  logic [AW-1:0] usr_araddr;
  logic [LW-1:0] usr_arlen;
  logic [SW-1:0] usr_arsize;
  logic [1:0]    usr_arburst;
  logic          usr_arvalid, usr_arready;
  logic [IW-1:0] usr_rid;
  logic [DW-1:0] usr_rdata;
  logic [1:0]    usr_rresp;
  logic          usr_rlast, usr_rvalid, usr_rready;
  logic [DW-1:0] dat_data;
  logic          dat_last, dat_valid, dat_ready;
  logic          busy, done, err;

  always #5 clk = ~clk;

  ami_rsplit dut (
    .usr_clk(clk), .usr_reset_n(usr_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_beats(cmd_beats), .cmd_id(cmd_id),
    .usr_arid(usr_arid), .usr_araddr(usr_araddr), .usr_arlen(usr_arlen),
    .usr_arsize(usr_arsize), .usr_arburst(usr_arburst),
    .usr_arvalid(usr_arvalid), .usr_arready(usr_arready),
    .usr_rid(usr_rid), .usr_rdata(usr_rdata), .usr_rresp(usr_rresp),
    .usr_rlast(usr_rlast), .usr_rvalid(usr_rvalid), .usr_rready(usr_rready),
    .dat_data(dat_data), .dat_last(dat_last), .dat_valid(dat_valid), .dat_ready(dat_ready),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] rq_len[$];
  int rbeat = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; usr_arready = 0; usr_rvalid = 0; usr_rlast = 0;
    usr_rresp = 0; dat_ready = 0; usr_rid = 0; usr_rdata = '0;
  endtask

  // One-cycle reset pulse; checks the cleared outputs and that a descriptor can follow.
  task automatic pulse_reset();
    idle_inputs();
    usr_reset_n = 0;
    @(negedge clk); #1;
    check("rst_arvalid", usr_arvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    usr_reset_n = 1;
    rq_len.delete();
    rbeat = 0;
    @(negedge clk); #1;
    check("rst_release_ready", cmd_ready, 1);
  endtask

  task automatic run_xfer(input logic [31:0] a, input int n, input logic [7:0] id,
                          input int p_ar, input int p_rv, input int p_dr,
                          input int err_beat, input int r_hold, input int rst_at);
    logic [31:0] ea[$];
    logic [7:0]  el[$];
    logic [31:0] m_a, p_addr;
    logic [7:0]  p_len;
    int m_n, b, room, nbursts, ar_cnt, outs, seen, last_rel, wait_cnt;
    bit err_exp, pend, got_done;

    // Reference burst list straight from the splitting rules.
    m_a = a & 32'hFFFF_FFF0;
    m_n = n;
    while (m_n > 0) begin
      room = (4096 - int'(m_a[11:0])) / 16;
      b = m_n;
      if (b > MBL) b = MBL;
      if (b > room) b = room;
      ea.push_back(m_a);
      el.push_back(8'(b - 1));
      m_a = m_a + 32'(b * 16);
      m_n -= b;
    end
    nbursts = ea.size();
    ar_cnt = 0; outs = 0; seen = 0; last_rel = 0; err_exp = 0; pend = 0; got_done = 0;
    p_addr = '0; p_len = '0;

    @(negedge clk); #1;
    wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 20) begin
      @(negedge clk); #1;
      wait_cnt++;
    end
    check("cmd_ready", cmd_ready, 1);
    if (!cmd_ready) return;
    idle_inputs();
    cmd_valid = 1; cmd_addr = a; cmd_beats = CLW'(n); cmd_id = id;

    for (int rel = 1; rel < 4000 && !got_done; rel++) begin
      @(negedge clk);
      cmd_valid = 0;
      if (rel == rst_at) begin
        pulse_reset();
        return;
      end
      usr_arready = ($urandom_range(99) < p_ar);
      dat_ready   = ($urandom_range(99) < p_dr);
      if (rq_len.size() > 0 && rel > r_hold && $urandom_range(99) < p_rv) begin
        usr_rvalid = 1;
        usr_rdata  = {$urandom, $urandom, $urandom, $urandom};
        usr_rlast  = (rbeat == int'(rq_len[0]));
        usr_rresp  = (seen + 1 == err_beat) ? 2'b10 : 2'b00;
        usr_rid    = id;
      end else begin
        usr_rvalid = 0; usr_rlast = 0; usr_rresp = 0;
      end
      #1;

      if (rel == 1) begin
        check("busy_start", busy, 1);
        check("err_clear", err, 0);
      end
      check("ar_valid", usr_arvalid, (ar_cnt < nbursts) && (outs < OD));
      if (pend) check("ar_hold", {usr_arvalid, usr_araddr, usr_arlen}, {1'b1, p_addr, p_len});
      if (r_hold > 0 && rel == r_hold) check("od_count", ar_cnt, (nbursts < OD) ? nbursts : OD);
      check("rready", usr_rready, dat_ready);
      check("dvalid", dat_valid, usr_rvalid);

      if (usr_arvalid && usr_arready) begin
        if (ea.size() == 0) begin
          check("ar_extra", usr_araddr, 0);
        end else begin
          check("ar_addr", usr_araddr, ea[0]);
          check("ar_len", usr_arlen, el[0]);
          check("ar_misc", {usr_arid, usr_arsize, usr_arburst}, {id, 3'd4, 2'b01});
          rq_len.push_back(el[0]);
          void'(ea.pop_front());
          void'(el.pop_front());
        end
        ar_cnt++;
        outs++;
      end
      if (usr_rvalid && usr_rready) begin
        seen++;
        check("dat_data", dat_data, usr_rdata);
        check("dat_last", dat_last, seen == n);
        if (usr_rresp != 2'b00) err_exp = 1;
        rbeat++;
        if (usr_rlast) begin
          void'(rq_len.pop_front());
          rbeat = 0;
          outs--;
        end
        if (seen == n) last_rel = rel;
      end

      if (done) begin
        got_done = 1;
        check("done_cyc", rel, (n == 0) ? 1 : last_rel + 1);
        check("ar_total", ar_cnt, nbursts);
        check("beats_total", seen, n);
        check("err_done", err, err_exp);
      end
      pend = usr_arvalid && !usr_arready;
      p_addr = usr_araddr;
      p_len  = usr_arlen;
    end

    if (!got_done) begin
      check("xfer_done", got_done, 1);
      pulse_reset();
      return;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("done_pulse", done, 0);
    check("idle_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);
    check("err_idle", err, err_exp);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    idle_inputs();
    cmd_addr = '0; cmd_beats = '0; cmd_id = '0;
    usr_reset_n = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 0);
    usr_reset_n = 1;
    @(negedge clk); #1;
    check("init_ready", cmd_ready, 1);
    check("init_ar", {usr_arvalid, usr_araddr, usr_arlen, usr_arsize, usr_arburst, usr_arid}, 0);
    check("init_status", {done, err, busy, dat_last}, 0);

    run_xfer(32'h0000_0000, 40, 8'h05, 100, 100, 100, 0, 0, 0);
    run_xfer(32'h0000_0FC0, 16, 8'h11, 60, 70, 60, 0, 0, 0);
    run_xfer(32'h0000_1000, 128, 8'h22, 100, 100, 100, 0, 20, 0);
    run_xfer(32'h0004_0A30, 60, 8'h33, 25, 80, 50, 0, 0, 0);
    run_xfer(32'h0000_2000, 10, 8'h44, 100, 100, 100, 3, 0, 0);
    run_xfer(32'h0000_3000, 8, 8'h45, 100, 100, 100, 0, 0, 0);
    run_xfer(32'h0000_4000, 0, 8'h46, 100, 100, 100, 0, 0, 0);
    run_xfer(32'hFFFF_FFC0, 20, 8'h47, 70, 70, 70, 0, 0, 0);
    run_xfer(32'h0000_5007, 200, 8'h48, 50, 100, 100, 1, 0, 8);
    run_xfer(32'h0000_6000, 33, 8'h49, 80, 80, 80, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      if (i % 3 == 0) a[11:0] = 12'hF00 | 12'($urandom_range(255));
      n = $urandom_range(1, 70);
      run_xfer(a, n, 8'($urandom), $urandom_range(30, 100), $urandom_range(30, 100),
               $urandom_range(30, 100), (i % 4 == 0) ? $urandom_range(1, n) : 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
